// File: rtl/snooze_down_timer.sv
// BCD mm:ss countdown timer with load, start/pause/abort and a one-cycle expiry pulse.
// Digits, BUSY and DONE are registered; ZERO is decoded combinationally from the digits.
module snooze_down_timer #(
  parameter int MAX_MT = 5
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Tick,
  input  logic       LD,
  input  logic       Start,
  input  logic       Stop,
  input  logic [2:0] IN_MT,
  input  logic [3:0] IN_MU,
  input  logic [2:0] IN_ST,
  input  logic [3:0] IN_SU,
  output logic [2:0] MT,
  output logic [3:0] MU,
  output logic [2:0] ST,
  output logic [3:0] SU,
  output logic       BUSY,
  output logic       DONE,
  output logic       ZERO
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PAUSE   = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  localparam logic [2:0] MT_LIM = 3'(MAX_MT);

  logic [1:0] state, state_nxt;
  logic [2:0] mt_nxt, dec_mt;
  logic [3:0] mu_nxt, dec_mu;
  logic [2:0] st_nxt, dec_st;
  logic [3:0] su_nxt, dec_su;
  logic       done_nxt;
  logic       dec_zero;

  function automatic logic [3:0] sat4(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  function automatic logic [2:0] sat3(input logic [2:0] d, input logic [2:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  assign ZERO = (MT == 3'd0) && (MU == 4'd0) && (ST == 3'd0) && (SU == 4'd0);

  // One-second borrow chain; only applied when the value is nonzero.
  always_comb begin
    dec_mt = MT;
    dec_mu = MU;
    dec_st = ST;
    dec_su = SU;
    if (SU != 4'd0) begin
      dec_su = SU - 4'd1;
    end else begin
      dec_su = 4'd9;
      if (ST != 3'd0) begin
        dec_st = ST - 3'd1;
      end else begin
        dec_st = 3'd5;
        if (MU != 4'd0) begin
          dec_mu = MU - 4'd1;
        end else begin
          dec_mu = 4'd9;
          dec_mt = MT - 3'd1;
        end
      end
    end
  end

  assign dec_zero = (dec_mt == 3'd0) && (dec_mu == 4'd0) &&
                    (dec_st == 3'd0) && (dec_su == 4'd0);

  always_comb begin
    state_nxt = state;
    mt_nxt    = MT;
    mu_nxt    = MU;
    st_nxt    = ST;
    su_nxt    = SU;
    done_nxt  = 1'b0;
    case (state)
      S_RUN: begin
        if (Stop) begin
          state_nxt = S_PAUSE;
        end else if (Tick && !ZERO) begin
          mt_nxt = dec_mt;
          mu_nxt = dec_mu;
          st_nxt = dec_st;
          su_nxt = dec_su;
          if (dec_zero) begin
            state_nxt = S_EXPIRED;
            done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        if (LD) begin
          state_nxt = S_IDLE;
          mt_nxt    = sat3(IN_MT, MT_LIM);
          mu_nxt    = sat4(IN_MU, 4'd9);
          st_nxt    = sat3(IN_ST, 3'd5);
          su_nxt    = sat4(IN_SU, 4'd9);
        end else if (Stop) begin
          if (state != S_IDLE) begin
            state_nxt = S_IDLE;
            mt_nxt    = 3'd0;
            mu_nxt    = 4'd0;
            st_nxt    = 3'd0;
            su_nxt    = 4'd0;
          end
        end else if (Start && !ZERO && (state != S_EXPIRED)) begin
          state_nxt = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state <= S_IDLE;
      MT    <= 3'd0;
      MU    <= 4'd0;
      ST    <= 3'd0;
      SU    <= 4'd0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_nxt;
      MT    <= mt_nxt;
      MU    <= mu_nxt;
      ST    <= st_nxt;
      SU    <= su_nxt;
      BUSY  <= (state_nxt == S_RUN);
      DONE  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_snooze_down_timer.sv
// Bench for snooze_down_timer: directed scenarios plus a randomized run against a
// reference model that tracks the remaining time as a plain count of seconds.
module tb_snooze_down_timer;
  localparam int MAX_MT = 5;

  logic       Clk = 1'b0;
  logic       Clr = 1'b0, Tick = 1'b0, LD = 1'b0, Start = 1'b0, Stop = 1'b0;
  logic [2:0] IN_MT = 3'd0;
  logic [3:0] IN_MU = 4'd0;
  logic [2:0] IN_ST = 3'd0;
  logic [3:0] IN_SU = 4'd0;
  logic [2:0] MT;
  logic [3:0] MU;
  logic [2:0] ST;
  logic [3:0] SU;
  logic       BUSY, DONE, ZERO;

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 run, 2 pause, 3 expired
  int m_secs  = 0;
  int m_state = 0;
  bit m_done  = 1'b0;

  snooze_down_timer #(.MAX_MT(MAX_MT)) dut (
    .Clk(Clk), .Clr(Clr), .Tick(Tick), .LD(LD), .Start(Start), .Stop(Stop),
    .IN_MT(IN_MT), .IN_MU(IN_MU), .IN_ST(IN_ST), .IN_SU(IN_SU),
    .MT(MT), .MU(MU), .ST(ST), .SU(SU),
    .BUSY(BUSY), .DONE(DONE), .ZERO(ZERO)
  );

  always #5 Clk = ~Clk;

  function automatic logic [13:0] bcd(input int mt, input int mu, input int st, input int su);
    return {3'(mt), 4'(mu), 3'(st), 4'(su)};
  endfunction

  function automatic logic [13:0] model_digits();
    return bcd(m_secs / 600, (m_secs / 60) % 10, (m_secs % 60) / 10, m_secs % 10);
  endfunction

  function automatic int load_val();
    int mt, mu, st, su;
    mt = (int'(IN_MT) > MAX_MT) ? MAX_MT : int'(IN_MT);
    mu = (int'(IN_MU) > 9) ? 9 : int'(IN_MU);
    st = (int'(IN_ST) > 5) ? 5 : int'(IN_ST);
    su = (int'(IN_SU) > 9) ? 9 : int'(IN_SU);
    return mt * 600 + mu * 60 + st * 10 + su;
  endfunction

  task automatic model_step();
    m_done = 1'b0;
    if (Clr) begin
      m_secs  = 0;
      m_state = 0;
    end else if (m_state == 1) begin
      if (Stop) m_state = 2;
      else if (Tick && m_secs > 0) begin
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_state = 3;
          m_done  = 1'b1;
        end
      end
    end else begin
      if (LD) begin
        m_secs  = load_val();
        m_state = 0;
      end else if (Stop) begin
        if (m_state != 0) begin
          m_secs  = 0;
          m_state = 0;
        end
      end else if (Start && m_secs > 0 && m_state != 3) begin
        m_state = 1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic step(input bit clr, input bit ld, input bit start, input bit stop, input bit tick);
    Clr = clr; LD = ld; Start = start; Stop = stop; Tick = tick;
    cyc();
    Clr = 1'b0; LD = 1'b0; Start = 1'b0; Stop = 1'b0; Tick = 1'b0;
  endtask

  task automatic set_in(input int mt, input int mu, input int st, input int su);
    IN_MT = 3'(mt); IN_MU = 4'(mu); IN_ST = 3'(st); IN_SU = 4'(su);
  endtask

  task automatic test_reset();
    set_in(3, 4, 5, 6);
    step(1, 1, 1, 1, 1);
    checks++;
    if ({MT, MU, ST, SU} !== 14'd0) begin
      errors++; $display("FAIL reset_digits: got %h expected %h", {MT, MU, ST, SU}, 14'd0);
    end
    checks++;
    if ({BUSY, DONE, ZERO} !== 3'b001) begin
      errors++; $display("FAIL reset_flags: got %b expected 001", {BUSY, DONE, ZERO});
    end
  endtask

  task automatic test_basic_expiry();
    logic [13:0] exp_d [3];
    exp_d[0] = bcd(0, 0, 0, 2); exp_d[1] = bcd(0, 0, 0, 1); exp_d[2] = bcd(0, 0, 0, 0);
    set_in(0, 0, 0, 3);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    checks++;
    if (BUSY !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", BUSY); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1);
      checks++;
      if ({MT, MU, ST, SU} !== exp_d[i]) begin
        errors++; $display("FAIL basic_tick%0d: got %h expected %h", i, {MT, MU, ST, SU}, exp_d[i]);
      end
      checks++;
      if (DONE !== (i == 2)) begin
        errors++; $display("FAIL basic_done%0d: got %b expected %b", i, DONE, (i == 2));
      end
      if (i < 2) for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
    end
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL basic_busy_exp: got %b expected 0", BUSY); end
    step(0, 0, 1, 0, 1);
    checks++;
    if ({DONE, BUSY, ZERO} !== 3'b001) begin
      errors++; $display("FAIL basic_after_exp: got %b expected 001", {DONE, BUSY, ZERO});
    end
  endtask

  task automatic test_borrow();
    set_in(1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    checks++;
    if ({MT, MU, ST, SU} !== bcd(0, 9, 5, 9)) begin
      errors++; $display("FAIL borrow_1: got %h expected %h", {MT, MU, ST, SU}, bcd(0, 9, 5, 9));
    end
    Tick = 1'b1;
    for (int i = 0; i < 60; i++) cyc();
    Tick = 1'b0;
    checks++;
    if ({MT, MU, ST, SU} !== bcd(0, 8, 5, 9)) begin
      errors++; $display("FAIL borrow_60: got %h expected %h", {MT, MU, ST, SU}, bcd(0, 8, 5, 9));
    end
    checks++;
    if (BUSY !== 1'b1) begin errors++; $display("FAIL borrow_busy: got %b expected 1", BUSY); end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_clamp();
    set_in(7, 12, 6, 15);
    step(0, 1, 0, 0, 0);
    checks++;
    if ({MT, MU, ST, SU} !== bcd(5, 9, 5, 9)) begin
      errors++; $display("FAIL clamp_over: got %h expected %h", {MT, MU, ST, SU}, bcd(5, 9, 5, 9));
    end
    set_in(5, 9, 5, 9);
    step(0, 1, 1, 0, 0);
    checks++;
    if ({MT, MU, ST, SU, BUSY} !== {bcd(5, 9, 5, 9), 1'b0}) begin
      errors++; $display("FAIL ld_start: got %h/%b expected %h/0", {MT, MU, ST, SU}, BUSY, bcd(5, 9, 5, 9));
    end
  endtask

  task automatic test_stop_tick();
    set_in(0, 2, 3, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    set_in(1, 1, 1, 1);
    step(0, 1, 0, 0, 0);
    checks++;
    if ({MT, MU, ST, SU, BUSY} !== {bcd(0, 2, 3, 0), 1'b1}) begin
      errors++; $display("FAIL ld_in_run: got %h/%b expected %h/1", {MT, MU, ST, SU}, BUSY, bcd(0, 2, 3, 0));
    end
    step(0, 0, 0, 1, 1);
    checks++;
    if ({MT, MU, ST, SU, BUSY} !== {bcd(0, 2, 3, 0), 1'b0}) begin
      errors++; $display("FAIL stop_tick: got %h/%b expected %h/0", {MT, MU, ST, SU}, BUSY, bcd(0, 2, 3, 0));
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if ({MT, MU, ST, SU} !== bcd(0, 2, 3, 0)) begin
      errors++; $display("FAIL pause_tick: got %h expected %h", {MT, MU, ST, SU}, bcd(0, 2, 3, 0));
    end
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    checks++;
    if ({MT, MU, ST, SU} !== bcd(0, 2, 2, 9)) begin
      errors++; $display("FAIL resume_tick: got %h expected %h", {MT, MU, ST, SU}, bcd(0, 2, 2, 9));
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    checks++;
    if ({MT, MU, ST, SU, BUSY, ZERO} !== {14'd0, 2'b01}) begin
      errors++; $display("FAIL stop_twice: got %h/%b%b expected 0000/01", {MT, MU, ST, SU}, BUSY, ZERO);
    end
  endtask

  task automatic test_clr_in_run();
    set_in(0, 0, 0, 5);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    set_in(3, 3, 3, 3);
    step(1, 1, 0, 0, 1);
    checks++;
    if ({MT, MU, ST, SU, BUSY, DONE} !== 16'd0) begin
      errors++; $display("FAIL clr_run: got %h/%b%b expected 0000/00", {MT, MU, ST, SU}, BUSY, DONE);
    end
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    checks++;
    if ({BUSY, ZERO} !== 2'b01) begin
      errors++; $display("FAIL start_zero: got %b expected 01", {BUSY, ZERO});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      Clr   = ($urandom_range(0, 199) == 0);
      LD    = ($urandom_range(0, 24) == 0);
      Start = ($urandom_range(0, 5) == 0);
      Stop  = ($urandom_range(0, 29) == 0);
      Tick  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0) set_in(0, 0, $urandom_range(0, 1), $urandom_range(0, 15));
      else set_in($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 15));
      cyc();
      Clr = 1'b0; LD = 1'b0; Start = 1'b0; Stop = 1'b0; Tick = 1'b0;
      checks++;
      if ({MT, MU, ST, SU} !== model_digits() || BUSY !== (m_state == 1) ||
          DONE !== m_done || ZERO !== (m_secs == 0)) begin
        errors++;
        $display("FAIL rand_%0d: got %h B%b D%b Z%b expected %h B%b D%b Z%b", i,
                 {MT, MU, ST, SU}, BUSY, DONE, ZERO,
                 model_digits(), (m_state == 1), m_done, (m_secs == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_expiry();
    test_borrow();
    test_clamp();
    test_stop_tick();
    test_clr_in_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
